// File: rtl/fetch_unit.sv
// Instruction fetch: streams a program into the IROM, then fetches words for the decoder.
// Latency: an address issued in cycle t is presented in t+1; there is one bubble on entry to RUN.
// Backpressure: load_ready drops once the ROM is full; stall re-reads the same address; redirect wins over stall.
module fetch_unit #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              setup,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    output logic              load_ready,
    input  logic [31:0]       first_addr,
    output logic              load_overflow,
    output logic [ADDR_W-1:0] irom_addr,
    output logic [31:0]       irom_wdata,
    output logic              irom_we,
    output logic              irom_re,
    input  logic [31:0]       irom_rdata,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_addr,
    output logic [31:0]       instr_out,
    output logic [31:0]       instr_pc,
    output logic [31:0]       instr_pc_plus4,
    output logic              instr_valid,
    output logic              misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       fa;
    logic [31:0]       fa_next;
    logic              valid_q;
    logic [ADDR_W:0]   load_ptr;
    logic              full;

    // The extra top bit of load_ptr marks a completely filled ROM.
    assign full = load_ptr[ADDR_W];

    // Next fetch address: redirect beats stall beats sequential. While nothing has
    // been presented yet (valid_q=0) fa is the first address to issue, so it is
    // not advanced; this yields exactly one bubble after entering RUN.
    always_comb begin
        fa_next = fa + 32'd4;
        if (redirect_valid) begin
            fa_next = redirect_addr & ~32'h3;
        end else if (stall || !valid_q) begin
            fa_next = fa;
        end
    end

    // Next-state and ROM-port decode.
    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        irom_we    = 1'b0;
        irom_re    = 1'b0;
        irom_addr  = '0;
        irom_wdata = 32'h0;
        unique case (state)
            IDLE: begin
                state_next = setup ? LOAD : RUN;
            end
            LOAD: begin
                load_ready = ~full;
                irom_addr  = load_ptr[ADDR_W-1:0];
                if (load_valid && !full) begin
                    irom_we    = 1'b1;
                    irom_wdata = load_data;
                end
                if (!setup) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                irom_re   = 1'b1;
                irom_addr = fa_next[ADDR_W+1:2];
                if (setup) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fetch address, presented PC, load pointer and sticky/pulse flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fa            <= RESET_PC;
            instr_pc      <= RESET_PC;
            valid_q       <= 1'b0;
            load_ptr      <= '0;
            load_overflow <= 1'b0;
            misalign      <= 1'b0;
        end else begin
            misalign <= 1'b0;
            unique case (state)
                IDLE: begin
                    fa      <= RESET_PC;
                    valid_q <= 1'b0;
                    if (setup) begin
                        load_ptr      <= '0;
                        load_overflow <= 1'b0;
                    end
                end
                LOAD: begin
                    valid_q <= 1'b0;
                    if (irom_we) begin
                        load_ptr <= load_ptr + (ADDR_W+1)'(1);
                    end
                    if (load_valid && full) begin
                        load_overflow <= 1'b1;
                    end
                    if (!setup) begin
                        fa <= first_addr & ~32'h3;
                    end
                end
                RUN: begin
                    if (setup) begin
                        load_ptr      <= '0;
                        valid_q       <= 1'b0;
                        load_overflow <= 1'b0;
                    end else begin
                        fa       <= fa_next;
                        instr_pc <= fa_next;
                        valid_q  <= 1'b1;
                        misalign <= redirect_valid && (redirect_addr[1:0] != 2'b00);
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // The decoder sees a NOP whenever the ROM data is not a real fetch.
    assign instr_out      = valid_q ? irom_rdata : NOP_WORD;
    assign instr_valid    = valid_q;
    assign instr_pc_plus4 = instr_pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W0  = 32'h0050_0093;
    localparam logic [31:0] W1  = 32'h0010_8113;
    localparam logic [31:0] W2  = 32'h0020_81B3;
    localparam logic [31:0] W3  = 32'h0000_0013;

    logic        clk = 1'b0;
    int          checks   = 0;
    int          failures = 0;

    // Instance A: default 256-word ROM with a behavioural ROM model.
    logic        rst, setup, load_valid, stall, redirect_valid;
    logic [31:0] load_data, first_addr, redirect_addr;
    logic        load_ready, load_overflow, irom_we, irom_re, instr_valid, misalign;
    logic [7:0]  irom_addr;
    logic [31:0] irom_wdata, instr_out, instr_pc, instr_pc_plus4;
    logic [31:0] irom_rdata;
    logic [31:0] mem [0:255];

    // Instance B: 4-word ROM for the overflow boundary.
    logic        b_rst, b_setup, b_load_valid;
    logic [31:0] b_load_data;
    logic        b_load_ready, b_load_overflow, b_irom_we, b_irom_re, b_instr_valid, b_misalign;
    logic [1:0]  b_irom_addr;
    logic [31:0] b_irom_wdata, b_instr_out, b_instr_pc, b_instr_pc_plus4;
    logic [31:0] b_irom_rdata = 32'h0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(8)) dut_a (
        .clk(clk), .rst(rst), .setup(setup),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .first_addr(first_addr), .load_overflow(load_overflow),
        .irom_addr(irom_addr), .irom_wdata(irom_wdata), .irom_we(irom_we),
        .irom_re(irom_re), .irom_rdata(irom_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4),
        .instr_valid(instr_valid), .misalign(misalign)
    );

    fetch_unit #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst(b_rst), .setup(b_setup),
        .load_valid(b_load_valid), .load_data(b_load_data), .load_ready(b_load_ready),
        .first_addr(32'h0), .load_overflow(b_load_overflow),
        .irom_addr(b_irom_addr), .irom_wdata(b_irom_wdata), .irom_we(b_irom_we),
        .irom_re(b_irom_re), .irom_rdata(b_irom_rdata),
        .stall(1'b0), .redirect_valid(1'b0), .redirect_addr(32'h0),
        .instr_out(b_instr_out), .instr_pc(b_instr_pc), .instr_pc_plus4(b_instr_pc_plus4),
        .instr_valid(b_instr_valid), .misalign(b_misalign)
    );

    // Synchronous ROM: write on we, registered read on re.
    always @(posedge clk) begin
        if (irom_we) mem[irom_addr] <= irom_wdata;
        if (irom_re) irom_rdata <= mem[irom_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_instr(input string tag, input logic [31:0] exp_instr, input logic [31:0] exp_pc);
        chk({tag, "_instr"}, instr_out, exp_instr);
        chk({tag, "_pc"}, instr_pc, exp_pc);
        chk({tag, "_pc4"}, instr_pc_plus4, exp_pc + 32'd4);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    endtask

    logic [31:0] words [0:3];

    initial begin
        words[0] = W0; words[1] = W1; words[2] = W2; words[3] = W3;
        rst = 1'b1; setup = 1'b0; load_valid = 1'b0; load_data = 32'h0;
        first_addr = 32'h0; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = 32'h0;
        b_rst = 1'b1; b_setup = 1'b0; b_load_valid = 1'b0; b_load_data = 32'h0;
        step(); step();

        // Reset state
        chk("rst_instr", instr_out, NOP);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_ready", {31'b0, load_ready}, 32'd0);
        chk("rst_we", {31'b0, irom_we}, 32'd0);
        chk("rst_re", {31'b0, irom_re}, 32'd0);
        chk("rst_ovf", {31'b0, load_overflow}, 32'd0);
        chk("rst_mis", {31'b0, misalign}, 32'd0);

        // Program load: IDLE -> LOAD, four back-to-back writes
        rst = 1'b0; setup = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1; load_data = words[i];
            #1;
            chk("ld_ready", {31'b0, load_ready}, 32'd1);
            chk("ld_we", {31'b0, irom_we}, 32'd1);
            chk("ld_addr", {24'b0, irom_addr}, i);
            chk("ld_wdata", irom_wdata, words[i]);
            chk("ld_instr_nop", instr_out, NOP);
            step();
        end
        load_valid = 1'b0; setup = 1'b0; first_addr = 32'h0;
        #1;
        chk("ld_we_off", {31'b0, irom_we}, 32'd0);
        step();

        // First RUN cycle is a bubble
        chk("bub_instr", instr_out, NOP);
        chk("bub_valid", {31'b0, instr_valid}, 32'd0);
        chk("bub_re", {31'b0, irom_re}, 32'd1);
        chk("bub_addr", {24'b0, irom_addr}, 32'd0);
        step();
        chk_instr("seq0", W0, 32'h0);
        step();
        chk_instr("seq1", W1, 32'h4);

        // Stall while presenting pc=4
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_instr("stall", W1, 32'h4);
        end
        stall = 1'b0;
        step();
        chk_instr("post_stall", W2, 32'h8);

        // Redirect to 0 during stall: redirect wins, no bubble
        stall = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'h0;
        step();
        chk_instr("redir0", W0, 32'h0);
        chk("redir0_mis", {31'b0, misalign}, 32'd0);

        // Misaligned redirect to 6 aligns down to 4
        stall = 1'b0; redirect_addr = 32'h6;
        step();
        chk_instr("redir6", W1, 32'h4);
        chk("redir6_mis", {31'b0, misalign}, 32'd1);
        redirect_valid = 1'b0;
        step();
        chk_instr("after6", W2, 32'h8);
        chk("after6_mis", {31'b0, misalign}, 32'd0);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFFC;
        step();
        chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", instr_pc_plus4, 32'h0);
        redirect_valid = 1'b0;
        step();
        chk_instr("wrap_next", W0, 32'h0);

        // Re-enter LOAD, write two words, then reset mid-load
        setup = 1'b1;
        step();
        chk("reload_ovf", {31'b0, load_overflow}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1; load_data = 32'hAAAA_0001 + i;
            #1;
            chk("reload_addr", {24'b0, irom_addr}, i);
            step();
        end
        rst = 1'b1;
        #1;
        chk("midrst_we", {31'b0, irom_we}, 32'd0);
        chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
        step();
        rst = 1'b0; setup = 1'b0; load_valid = 1'b0;
        step();
        chk("midrst_bub_instr", instr_out, NOP);
        chk("midrst_bub_valid", {31'b0, instr_valid}, 32'd0);
        step();
        chk_instr("midrst_w0", 32'hAAAA_0001, 32'h0);

        // Overflow on a 4-word ROM
        b_rst = 1'b0; b_setup = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            b_load_valid = 1'b1; b_load_data = 32'h5500_0000 + i;
            #1;
            chk("b_ready", {31'b0, b_load_ready}, 32'd1);
            chk("b_we", {31'b0, b_irom_we}, 32'd1);
            chk("b_addr", {30'b0, b_irom_addr}, i);
            step();
        end
        chk("b_full_ready", {31'b0, b_load_ready}, 32'd0);
        chk("b_full_we", {31'b0, b_irom_we}, 32'd0);
        chk("b_ovf_before", {31'b0, b_load_overflow}, 32'd0);
        step();
        chk("b_ovf_set", {31'b0, b_load_overflow}, 32'd1);
        b_load_valid = 1'b0;
        step();
        chk("b_ovf_sticky", {31'b0, b_load_overflow}, 32'd1);
        b_setup = 1'b0;
        step();
        b_setup = 1'b1;
        step();
        chk("b_reload_ovf", {31'b0, b_load_overflow}, 32'd0);
        chk("b_reload_ready", {31'b0, b_load_ready}, 32'd1);
        chk("b_reload_ptr", {30'b0, b_irom_addr}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder. It produces the 32-bit instruction word and its PC for the decoder.
- During setup it streams a program into the instruction ROM: sequential write words, then a start address.
- During run it keeps the PC, issues synchronous ROM reads, and applies stall and branch/jump redirects from the execute stage.
- It presents the canonical NOP (32'h00000013) whenever no valid instruction is available.

Parameters:
- ADDR_W, 8, IROM word-index width; depth = 2^ADDR_W words.
- RESET_PC, 32'h00000000, PC value after reset.
- NOP_WORD, 32'h00000013, word driven on instr_out when instr_valid=0.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- setup  in  1  1 = program-load mode; 0 = run.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  32  program word to write.
- load_ready  out  1  loader accepts a word this cycle.
- first_addr  in  32  start PC, sampled on the setup 1->0 edge.
- load_overflow  out  1  sticky: a word was offered after the ROM was full.
- irom_addr  out  ADDR_W  ROM word index (write or read).
- irom_wdata  out  32  ROM write data.
- irom_we  out  1  ROM write enable.
- irom_re  out  1  ROM read enable.
- irom_rdata  in  32  ROM read data, valid one cycle after the address is issued.
- stall  in  1  hold the current instruction.
- redirect_valid  in  1  branch taken, JAL or JALR.
- redirect_addr  in  32  redirect target.
- instr_out  out  32  instruction to the decoder.
- instr_pc  out  32  PC of instr_out.
- instr_pc_plus4  out  32  instr_pc + 4, the return address.
- instr_valid  out  1  instr_out is a real fetched instruction.
- misalign  out  1  one-cycle pulse: redirect_addr[1:0] != 0.

Behaviour:
Reset (async, rst=1):
- state=IDLE, fa (fetch address)=RESET_PC, instr_pc=RESET_PC, valid_q=0, load_ptr=0.
- load_overflow=0, misalign=0, load_ready=0, irom_we=0, irom_re=0.
- instr_out=NOP_WORD, instr_valid=0.

States and transitions:
- IDLE -> LOAD when setup=1.
- IDLE -> RUN when setup=0, with fa=RESET_PC.
- LOAD -> RUN on setup=0; fa <= first_addr with bits [1:0] forced to 00.
- RUN -> LOAD when setup=1: load_ptr<=0, valid_q<=0, load_overflow cleared.
- rst mid-operation returns to IDLE immediately; no partial write completes.

LOAD state:
- irom_re=0; load_ready = ~full. full = (load_ptr == 2^ADDR_W).
- Handshake: on load_valid & load_ready, drive irom_we=1, irom_addr=load_ptr[ADDR_W-1:0], irom_wdata=load_data; load_ptr++ (ADDR_W+1 bits, no wrap).
- load_valid while full: word dropped, load_overflow<=1 (sticky until next LOAD entry or reset).
- instr_valid=0 and instr_out=NOP_WORD throughout.

RUN state:
- irom_re=1; irom_we=0; load_ready=0.
- Next-address select, priority redirect > stall > sequential:
  - fa_next = {redirect_addr[31:2],2'b00} if redirect_valid;
  - else fa if stall;
  - else fa+4.
- irom_addr = fa_next[ADDR_W+1:2] (combinational). Higher bits are ignored, so addresses wrap modulo ROM size.
- Registers update each cycle: fa<=fa_next, instr_pc<=fa_next, valid_q<=1.
- instr_out = valid_q ? irom_rdata : NOP_WORD; instr_valid = valid_q. instr_pc_plus4 = instr_pc+4 (32-bit wrap).
- Latency: an address issued at cycle t is presented at t+1. The first instruction appears one cycle after RUN entry; that cycle is a single bubble with instr_valid=0.
- Stall: the same address is re-read, so instr_out/instr_pc are held stable for the whole stall.
- Redirect: the target instruction is presented the next cycle, with no bubble. Redirect during stall is taken (redirect wins).
- misalign<=1 for one cycle when redirect_valid and redirect_addr[1:0]!=0; the target is still aligned down.
- PC wrap 32'hFFFFFFFC+4 -> 0.

Test Plan:
- Load 4 words {0x00500093,0x00108113,0x002081B3,0x00000013} with load_valid held, then drop setup with first_addr=0 -> irom_we pulses with addresses 0..3; one bubble cycle (instr_out=0x13, instr_valid=0); then instr_out=0x00500093/pc=0, 0x00108113/pc=4, 0x002081B3/pc=8 on consecutive cycles; instr_pc_plus4=pc+4.
- stall=1 for 3 cycles while presenting pc=4 -> instr_out=0x00108113, pc=4 held 3 cycles; pc=8 appears the cycle after stall drops.
- redirect_valid with redirect_addr=0x0 while presenting pc=8, same cycle as stall=1 -> next cycle pc=0, instr_out=0x00500093, misalign=0.
- redirect_addr=0x6 -> next cycle pc=4, misalign high exactly one cycle.
- ADDR_W=2: offer 5 words in LOAD -> 4 writes, load_ready low after the 4th, load_overflow=1. Re-enter LOAD via setup -> load_overflow=0, load_ptr=0.
- Assert rst mid-LOAD after 2 writes, release with setup=0 -> state RUN from RESET_PC=0; instr_out=NOP_WORD and instr_valid=0 on the first cycle, ROM word 0 on the next.
